// File: rtl/output_limit_reader_pkg.sv
// Shared definitions for the output-limit readout path and its FIFO side.
//   LIMIT_W     : width of the FIFO's readable-word count
//   HDR_COUNT_W : number of count bits carried in the packet header word
//   state_t     : 3-bit readout FSM encoding
package output_limit_reader_pkg;

  localparam int unsigned LIMIT_W     = 16;
  localparam int unsigned HDR_COUNT_W = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LATCH      = 3'd1,
    WAIT_LIMIT = 3'd2,
    HEADER     = 3'd3,
    STREAM     = 3'd4,
    FINISH     = 3'd5
  } state_t;

endpackage

// File: rtl/output_limit_reader_if.sv
// FIFO-side and downstream-side signals of the output-limit reader.
//   reg_output_limit      : strobe asking the FIFO to latch its readable amount
//   output_limit          : latched word count from the FIFO
//   output_limit_not_done : FIFO still holds words inside the latched limit
//   fifo_dout/fifo_empty  : first-word-fall-through read data / empty flag
//   fifo_rd_en            : pop strobe
//   out_data/out_valid/out_ready : downstream valid/ready word port
// master = the reader, slave = FIFO plus downstream consumer.
interface output_limit_reader_if
  import output_limit_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic               reg_output_limit;
  logic [LIMIT_W-1:0] output_limit;
  logic               output_limit_not_done;
  logic [WIDTH-1:0]   fifo_dout;
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output reg_output_limit, fifo_rd_en, out_data, out_valid,
    input  output_limit, output_limit_not_done, fifo_dout, fifo_empty, out_ready
  );

  modport slave (
    input  reg_output_limit, fifo_rd_en, out_data, out_valid,
    output output_limit, output_limit_not_done, fifo_dout, fifo_empty, out_ready
  );

endinterface

// File: rtl/output_limit_reader.sv
// Reads one packet out of a FIFO: latches the FIFO's readable count, emits a
// header word holding that count, then streams exactly that many words.
// A watchdog aborts a stalled packet and raises a sticky err_timeout.
//   CLK, rst    : clock, synchronous active-high reset
//   start       : request a packet (sampled in IDLE only)
//   busy        : not in IDLE
//   done        : one-cycle pulse on normal completion
//   err_timeout : sticky stall flag, cleared by rst or a new start
//   bus         : FIFO and downstream port (master side)
module output_limit_reader
  import output_limit_reader_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TIMEOUT_MSB = 15
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output_limit_reader_if.master bus
);

  localparam int unsigned WD_W = TIMEOUT_MSB + 1;

  state_t             state;
  logic [LIMIT_W-1:0] remaining;
  logic [WD_W-1:0]    wd_cnt;

  logic accept_c;
  logic rd_c;
  logic hdr_load_c;
  logic leave_c;
  logic stalled_c;
  logic expire_c;

  assign accept_c   = bus.out_valid && bus.out_ready;
  assign hdr_load_c = (state == HEADER) && (!bus.out_valid || bus.out_ready);

  // Pop only while words remain and the output register is free this cycle;
  // gated by rst so a reset mid-packet never pops another word.
  assign rd_c = !rst && (state == STREAM) && (remaining != '0) &&
                !bus.fifo_empty && (!bus.out_valid || bus.out_ready);
  assign bus.fifo_rd_en = rd_c;

  // Conditions that move the FSM out of the watched states.
  always_comb begin
    leave_c = 1'b0;
    case (state)
      HEADER:  leave_c = hdr_load_c;
      STREAM:  leave_c = (remaining == '0);
      FINISH:  leave_c = !bus.out_valid && !bus.output_limit_not_done;
      default: leave_c = 1'b0;
    endcase
  end

  // A watched cycle with no load, accept or state change counts as stalled.
  assign stalled_c = (state inside {HEADER, STREAM, FINISH}) &&
                     !leave_c && !rd_c && !accept_c;
  assign expire_c  = stalled_c && (wd_cnt == {WD_W{1'b1}});

  // FSM, output register, remaining counter and watchdog.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state                <= IDLE;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      err_timeout          <= 1'b0;
      bus.reg_output_limit <= 1'b0;
      bus.out_data         <= '0;
      bus.out_valid        <= 1'b0;
      remaining            <= '0;
      wd_cnt               <= '0;
    end else begin
      done                 <= 1'b0;
      bus.reg_output_limit <= 1'b0;

      // Output register: a load takes priority, so pop+accept has no bubble.
      if (hdr_load_c) begin
        bus.out_data  <= WIDTH'(remaining[HDR_COUNT_W-1:0]);
        bus.out_valid <= 1'b1;
      end else if (rd_c) begin
        bus.out_data  <= bus.fifo_dout;
        bus.out_valid <= 1'b1;
        remaining     <= remaining - LIMIT_W'(1);
      end else if (accept_c) begin
        bus.out_valid <= 1'b0;
      end

      if (stalled_c) wd_cnt <= wd_cnt + WD_W'(1);
      else           wd_cnt <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            state                <= LATCH;
            busy                 <= 1'b1;
            bus.reg_output_limit <= 1'b1;
            err_timeout          <= 1'b0;
          end
        end
        LATCH:      state <= WAIT_LIMIT;
        WAIT_LIMIT: begin
          remaining <= bus.output_limit;
          state     <= HEADER;
        end
        HEADER: if (leave_c) state <= STREAM;
        STREAM: if (leave_c) state <= FINISH;
        FINISH: begin
          if (leave_c) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Watchdog abort overrides everything above.
      if (expire_c) begin
        err_timeout   <= 1'b1;
        bus.out_valid <= 1'b0;
        busy          <= 1'b0;
        done          <= 1'b0;
        state         <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_output_limit_reader.sv
// Directed bench for output_limit_reader with a behavioural limit-latching FIFO.
module tb_output_limit_reader;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned TO_MSB    = 5;
  localparam int          TO_CYCLES = 1 << (TO_MSB + 1);

  logic CLK = 1'b0;
  logic rst, start, busy, done, err_timeout;

  output_limit_reader_if #(.WIDTH(WIDTH)) bus ();

  output_limit_reader #(.WIDTH(WIDTH), .TIMEOUT_MSB(TO_MSB)) dut (
    .CLK(CLK), .rst(rst), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Downstream ready: fixed level or toggling every cycle.
  logic ready_mode, ready_fixed;
  logic tog = 1'b0;
  always @(posedge CLK) tog <= ~tog;
  assign bus.out_ready = ready_mode ? tog : ready_fixed;

  // FIFO model: output_limit latches the current fill on reg_output_limit;
  // words pushed later lie outside that limit.
  logic        push_en;
  logic [15:0] push_data;
  logic [15:0] fq[$];
  int          lim_left;
  always @(posedge CLK) begin
    if (rst) begin
      fq.delete();
      lim_left         <= 0;
      bus.output_limit <= '0;
    end else begin
      if (bus.fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
      if (bus.reg_output_limit) begin
        bus.output_limit <= 16'(fq.size());
        lim_left         <= fq.size();
      end else if (bus.fifo_rd_en && lim_left > 0) begin
        lim_left <= lim_left - 1;
      end
      if (push_en) fq.push_back(push_data);
    end
    bus.fifo_dout  <= (fq.size() > 0) ? fq[0] : '0;
    bus.fifo_empty <= (fq.size() == 0);
  end
  assign bus.output_limit_not_done = (lim_left != 0);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: accepted words, pops, done pulses, hold stability.
  logic [WIDTH-1:0] rx[$];
  int               rx_cyc[$];
  int               pop_cnt = 0, done_cnt = 0, cyc = 0;
  logic             chk_hold;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;
  always @(negedge CLK) begin
    cyc++;
    if (!rst) begin
      if (bus.fifo_rd_en) pop_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        rx.push_back(bus.out_data);
        rx_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (chk_hold && hold_prev) begin
        check("hold_data", 32'(bus.out_data), 32'(hold_data));
        check("hold_valid", 32'(bus.out_valid), 32'd1);
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_en   = 1'b1;
      push_data = 16'(base + 16'(i));
      tick();
    end
    push_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
    tick();
  endtask

  task automatic expect_packet(input string tag, input int base, input logic [15:0] hdr,
                               input logic [15:0] first, input int n);
    check($sformatf("%s_len", tag), 32'(rx.size() - base), 32'(n + 1));
    if (rx.size() >= base + n + 1) begin
      check($sformatf("%s_hdr", tag), 32'(rx[base]), 32'(hdr));
      for (int i = 0; i < n; i++)
        check($sformatf("%s_w%0d", tag, i), 32'(rx[base + 1 + i]), 32'(first + 16'(i)));
    end
  endtask

  int rb, pb, db, stall;
  bit seen;

  initial begin
    rst = 1'b1; start = 1'b0; push_en = 1'b0; push_data = '0;
    ready_mode = 1'b0; ready_fixed = 1'b1; chk_hold = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_reglim", 32'(bus.reg_output_limit), 32'd0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    rst = 1'b0;
    tick();

    // Five preloaded words, always ready: back-to-back header + data.
    push_words(16'h0101, 5);
    rb = rx.size(); pb = pop_cnt; db = done_cnt;
    pulse_start();
    @(negedge CLK);
    check("t1_reglim_on", 32'(bus.reg_output_limit), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    @(negedge CLK);
    check("t1_reglim_off", 32'(bus.reg_output_limit), 32'd0);
    tick();
    wait_done("t1_done", 60);
    repeat (3) tick();
    expect_packet("t1", rb, 16'h0005, 16'h0101, 5);
    check("t1_pops", 32'(pop_cnt - pb), 32'd5);
    check("t1_done_cnt", 32'(done_cnt - db), 32'd1);
    if (rx_cyc.size() >= rb + 6) check("t1_b2b", 32'(rx_cyc[rb + 5] - rx_cyc[rb]), 32'd5);
    check("t1_idle", 32'(busy), 32'd0);

    // Empty FIFO: header 0 only, no pops.
    rb = rx.size(); pb = pop_cnt; db = done_cnt;
    pulse_start();
    wait_done("t2_done", 40);
    repeat (2) tick();
    expect_packet("t2", rb, 16'h0000, 16'h0000, 0);
    check("t2_pops", 32'(pop_cnt - pb), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - db), 32'd1);

    // Four words with ready toggling: order kept, data held while stalled.
    push_words(16'h0201, 4);
    rb = rx.size(); pb = pop_cnt;
    ready_mode = 1'b1; chk_hold = 1'b1;
    pulse_start();
    wait_done("t3_done", 100);
    chk_hold = 1'b0; ready_mode = 1'b0;
    repeat (2) tick();
    expect_packet("t3", rb, 16'h0004, 16'h0201, 4);
    check("t3_pops", 32'(pop_cnt - pb), 32'd4);

    // Words arriving after the latch belong to the next packet.
    push_words(16'h0301, 2);
    rb = rx.size(); pb = pop_cnt;
    pulse_start();
    tick();
    push_words(16'h0311, 2);
    wait_done("t4a_done", 60);
    repeat (2) tick();
    expect_packet("t4a", rb, 16'h0002, 16'h0301, 2);
    check("t4a_pops", 32'(pop_cnt - pb), 32'd2);
    rb = rx.size();
    pulse_start();
    wait_done("t4b_done", 60);
    repeat (2) tick();
    expect_packet("t4b", rb, 16'h0002, 16'h0311, 2);

    // Downstream never ready: watchdog fires after TO_CYCLES stalled cycles.
    ready_fixed = 1'b0;
    push_words(16'h0401, 3);
    pb = pop_cnt; db = done_cnt;
    pulse_start();
    seen = 1'b0; stall = 0;
    for (int i = 0; i < TO_CYCLES + 50; i++) begin
      @(negedge CLK);
      if (err_timeout) begin
        seen = 1'b1;
        break;
      end
      if (bus.out_valid) stall++;
    end
    check("t5_err_set", 32'(seen), 32'd1);
    check("t5_stall_len", 32'(stall), 32'(TO_CYCLES));
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_no_done", 32'(done_cnt - db), 32'd0);
    check("t5_no_pops", 32'(pop_cnt - pb), 32'd0);
    tick();
    repeat (3) tick();
    check("t5_sticky", 32'(err_timeout), 32'd1);
    ready_fixed = 1'b1;
    rb = rx.size();
    pulse_start();
    @(negedge CLK);
    check("t5_err_clr", 32'(err_timeout), 32'd0);
    tick();
    wait_done("t5b_done", 60);
    repeat (2) tick();
    expect_packet("t5b", rb, 16'h0003, 16'h0401, 3);

    // Reset mid-stream after two data words.
    push_words(16'h0501, 6);
    rb = rx.size(); pb = pop_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      #1;
      if (rx.size() - rb >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_reached", 32'(seen), 32'd1);
    check("t6_pops_before", 32'(pop_cnt - pb), 32'd3);
    rst = 1'b1;
    #1;
    check("t6_rd_gated", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_data", 32'(bus.out_data), 32'd0);
    check("t6_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    rst = 1'b0;
    tick();
    @(negedge CLK);
    check("t6_rd_idle", 32'(bus.fifo_rd_en), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    if (rx.size() >= rb + 3) begin
      check("t6_hdr", 32'(rx[rb]), 32'h0006);
      check("t6_w0", 32'(rx[rb + 1]), 32'h0501);
      check("t6_w1", 32'(rx[rb + 2]), 32'h0502);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
